// File: rtl/rv_core_pkg.sv
// Shared core definitions: widths, reset PC, NOP encoding,
// fetch-state encoding and a word-alignment helper.
package rv_core_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_EMPTY,
    FS_INFLIGHT,
    FS_HELD,
    FS_BAD
  } fetch_state_e;

  function automatic logic [31:0] align_word(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry PC+instruction holding register.
// Ports: i_load/i_clear control, i_pc/i_instr in, o_valid/o_pc/o_instr out.
module if_skid_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;

  // Clear wins so a redirect always drops a held entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: PC, imem request, response/skid pairing, redirect.
// Ports: clk/rst_n, imem_*, redirect_*, if_valid/if_ready/if_pc/if_instr.
module if_fetch_unit #(
  parameter int              XLEN     = rv_core_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC =
    rv_core_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_req,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
);
  import rv_core_pkg::*;

  logic [XLEN-1:0] r_pc;
  logic            r_rsp_valid;
  logic [XLEN-1:0] r_rsp_pc;

  logic            w_skid_valid;
  logic [XLEN-1:0] w_skid_pc;
  logic [XLEN-1:0] w_skid_instr;
  logic            w_skid_load;
  logic            w_skid_clear;

  fetch_state_e    w_state;
  logic            w_issue;
  logic [XLEN-1:0] w_fetch_pc;

  always_comb begin
    w_state = FS_EMPTY;
    case ({w_skid_valid, r_rsp_valid})
      2'b00:   w_state = FS_EMPTY;
      2'b01:   w_state = FS_INFLIGHT;
      2'b10:   w_state = FS_HELD;
      default: w_state = FS_BAD;
    endcase
  end

  always_comb begin
    if_pc    = '0;
    if_instr = '0;
    case (w_state)
      FS_HELD: begin
        if_pc    = w_skid_pc;
        if_instr = w_skid_instr;
      end
      FS_INFLIGHT: begin
        if_pc    = r_rsp_pc;
        if_instr = imem_instr;
      end
      default: begin
        if_pc    = '0;
        if_instr = '0;
      end
    endcase
  end

  assign if_valid = (w_skid_valid | r_rsp_valid)
                  & ~redirect_valid;

  assign w_issue = ~(if_valid & ~if_ready);

  assign w_fetch_pc = redirect_valid
                    ? align_word(redirect_pc)
                    : r_pc;

  assign imem_addr = {2'b00, w_fetch_pc[XLEN-1:2]};

  // Memory reads every cycle; the flag only reports real issues.
  assign imem_req = w_issue & rst_n;

  assign w_skid_load  = (w_state == FS_INFLIGHT)
                      & if_valid & ~if_ready;
  assign w_skid_clear = redirect_valid
                      | ((w_state == FS_HELD) & if_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_rsp_valid <= 1'b0;
      r_rsp_pc    <= '0;
    end else if (w_issue) begin
      r_pc        <= w_fetch_pc + XLEN'(4);
      r_rsp_valid <= 1'b1;
      r_rsp_pc    <= w_fetch_pc;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  if_skid_buf #(
    .XLEN(XLEN)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_rsp_pc),
    .i_instr (imem_instr),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_instr (w_skid_instr)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with word[k]=k+1 memory.
// Table of per-cycle vectors plus hand sequences for reset.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int compared;
  int mismatched;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [31:0] eaddr;
    logic        ereq;
  } vec_t;

  vec_t vec [17];

  if_fetch_unit #(
    .XLEN(32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_req       (imem_req),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory read: word[k] = k + 1.
  initial imem_instr = 32'h0;
  always @(posedge clk) imem_instr <= imem_addr + 32'd1;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Response and skid must never be live together.
  always @(negedge clk) begin
    if (rst_n) begin
      compared++;
      if (dut.r_rsp_valid && dut.w_skid_valid) begin
        mismatched++;
        $display("FAIL state: rsp and skid both valid");
      end
    end
  end

  initial begin
    compared       = 0;
    mismatched     = 0;
    rst_n          = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // rdy rv rpc | ev epc ein eaddr ereq
    vec[0]  = '{1, 0, 0, 0, 0, 0, 0, 1};
    vec[1]  = '{1, 0, 0, 1, 0, 1, 1, 1};
    vec[2]  = '{1, 0, 0, 1, 4, 2, 2, 1};
    vec[3]  = '{0, 0, 0, 1, 8, 3, 3, 0};
    vec[4]  = '{0, 0, 0, 1, 8, 3, 3, 0};
    vec[5]  = '{0, 0, 0, 1, 8, 3, 3, 0};
    vec[6]  = '{1, 0, 0, 1, 8, 3, 3, 1};
    vec[7]  = '{1, 0, 0, 1, 12, 4, 4, 1};
    vec[8]  = '{1, 1, 32'h20, 0, 0, 0, 8, 1};
    vec[9]  = '{1, 0, 0, 1, 32'h20, 9, 9, 1};
    vec[10] = '{0, 0, 0, 1, 32'h24, 10, 10, 0};
    vec[11] = '{0, 1, 32'h23, 0, 0, 0, 8, 1};
    vec[12] = '{1, 0, 0, 1, 32'h20, 9, 9, 1};
    vec[13] = '{1, 0, 0, 1, 32'h24, 10, 10, 1};
    vec[14] = '{1, 1, 32'hFFFF_FFFC, 0, 0, 0,
                32'h3FFF_FFFF, 1};
    vec[15] = '{1, 0, 0, 1, 32'hFFFF_FFFC,
                32'h4000_0000, 0, 1};
    vec[16] = '{1, 0, 0, 1, 0, 1, 1, 1};

    #2;
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);

    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      if_ready       = vec[i].rdy;
      redirect_valid = vec[i].rv;
      redirect_pc    = vec[i].rpc;
      #1;
      check($sformatf("v%0d_valid", i),
            {31'd0, if_valid}, {31'd0, vec[i].ev});
      if (vec[i].ev) begin
        check($sformatf("v%0d_pc", i),
              if_pc, vec[i].epc);
        check($sformatf("v%0d_instr", i),
              if_instr, vec[i].ein);
      end
      check($sformatf("v%0d_addr", i),
            imem_addr, vec[i].eaddr);
      check($sformatf("v%0d_req", i),
            {31'd0, imem_req}, {31'd0, vec[i].ereq});
    end

    // Stall on PC 4, then reset while the skid holds it.
    @(negedge clk);
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check("h1_pc", if_pc, 32'd4);
    check("h1_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    #1;
    check("h2_valid", {31'd0, if_valid}, 32'd1);
    check("h2_pc", if_pc, 32'd4);
    check("h2_instr", if_instr, 32'd2);
    rst_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, if_valid}, 32'd0);
    check("ar_pc", if_pc, 32'd0);
    check("ar_req", {31'd0, imem_req}, 32'd0);
    check("ar_addr", imem_addr, 32'd0);

    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    if_ready = 1'b1;
    #1;
    check("rr_valid", {31'd0, if_valid}, 32'd0);
    check("rr_addr", imem_addr, 32'd0);
    check("rr_req", {31'd0, imem_req}, 32'd1);
    @(negedge clk);
    #1;
    check("rr1_valid", {31'd0, if_valid}, 32'd1);
    check("rr1_pc", if_pc, 32'd0);
    check("rr1_instr", if_instr, 32'd1);
    check("rr1_addr", imem_addr, 32'd1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
